// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receive engine with a 2-FF input synchroniser, a one-cycle load strobe and sticky status flags.
// Defining UART_RX_PARITY_EN adds an even-parity bit after the data bits and a sticky parity_err output.
module uart_rx_core #(
   parameter int BAUD_DIV = 10416,
   parameter int CNT_W    = 14
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_load,
   output logic       rx_rdy,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic [2:0] o_dbg_state
);

   // rx_load is a valid-only strobe with no backpressure; rx_rdy is set on each load and held
   // until rx_ack, so a consumer that misses the strobe can still poll for the byte.

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
      , S_PARITY = 3'd5
`endif
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic [7:0]       r_data;
   logic             r_load;
   logic             r_rdy;
   logic             r_ferr;
   logic             r_ovr;
   logic             w_rxs;
   logic             w_sample;
   logic             w_cnt_half;
   logic             w_cnt_full;
   logic             w_shift_en;
   logic             w_load_ev;
   logic             w_frame_ev;
`ifdef UART_RX_PARITY_EN
   logic             r_perr;
   logic             w_par_ev;
`endif

   assign w_rxs    = r_sync2;
   assign w_sample = (r_cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_half  = 1'b0;
      w_cnt_full  = 1'b0;
      w_shift_en  = 1'b0;
      w_load_ev   = 1'b0;
      w_frame_ev  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_ev    = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (!w_rxs) begin
               w_state_nxt = S_START;
               w_cnt_half  = 1'b1;
            end
         end
         S_START: begin
            if (w_sample) begin
               if (!w_rxs) begin
                  w_state_nxt = S_DATA;
                  w_cnt_full  = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (w_sample) begin
               w_shift_en = 1'b1;
               w_cnt_full = 1'b1;
               if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_sample) begin
               w_par_ev    = 1'b1;
               w_cnt_full  = 1'b1;
               w_state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_sample) begin
               if (w_rxs) begin
                  w_load_ev   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_frame_ev  = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (w_rxs) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_load    <= 1'b0;
         r_rdy     <= 1'b0;
         r_ferr    <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         if (w_cnt_half)      r_cnt <= CNT_HALF;
         else if (w_cnt_full) r_cnt <= CNT_FULL;
         else if (!w_sample)  r_cnt <= r_cnt - CNT_ONE;
         if (r_state != S_DATA) r_bit_idx <= '0;
         else if (w_shift_en)   r_bit_idx <= r_bit_idx + 3'd1;
         if (w_shift_en) r_shift <= {w_rxs, r_shift[7:1]};
         if (w_load_ev) r_data <= r_shift;
         r_load <= w_load_ev;
         // An ack landing with a new byte keeps rdy set and suppresses overrun.
         if (w_load_ev)   r_rdy <= 1'b1;
         else if (rx_ack) r_rdy <= 1'b0;
         if (w_load_ev && r_rdy && !rx_ack) r_ovr <= 1'b1;
         else if (rx_ack)                   r_ovr <= 1'b0;
         if (w_frame_ev)  r_ferr <= 1'b1;
         else if (rx_ack) r_ferr <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_perr <= 1'b0;
      end else if (w_par_ev && ((^r_shift) ^ w_rxs)) begin
         r_perr <= 1'b1;
      end else if (rx_ack) begin
         r_perr <= 1'b0;
      end
   end
   assign parity_err = r_perr;
`endif

   assign rx_data     = r_data;
   assign rx_load     = r_load;
   assign rx_rdy      = r_rdy;
   assign rx_busy     = (r_state != S_IDLE);
   assign frame_err   = r_ferr;
   assign overrun     = r_ovr;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at BAUD_DIV=16: serial frames are driven bit by bit and checked against
// a frame-level model (expected byte queue plus sticky flag bits).
module tb_uart_rx_core;

   localparam int BD = 16;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = BD * 21 / 2 + 3;
`else
   localparam int LAT = BD * 19 / 2 + 3;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_load;
   logic       rx_rdy;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;
   logic [2:0] o_dbg_state;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
   logic       m_perr;
`endif

   int         total;
   int         bad;
   int         cyc;
   int         start_cyc;
   int         last_load_cyc;
   int         load_cnt;
   logic       prev_load;
   logic [7:0] sb_e;
   logic [7:0] exp_q[$];

   logic [7:0] m_data;
   logic       m_rdy;
   logic       m_ovr;
   logic       m_ferr;

   uart_rx_core #(.BAUD_DIV(BD), .CNT_W(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .rx_ack      (rx_ack),
      .rx_data     (rx_data),
      .rx_load     (rx_load),
      .rx_rdy      (rx_rdy),
      .rx_busy     (rx_busy),
      .frame_err   (frame_err),
      .overrun     (overrun),
`ifdef UART_RX_PARITY_EN
      .parity_err  (parity_err),
`endif
      .o_dbg_state (o_dbg_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Scoreboard: every load strobe must match the next expected byte and never repeat on adjacent cycles
   always @(negedge clk) begin
      if (rx_load === 1'b1) begin
         load_cnt++;
         last_load_cyc = cyc;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_load: got data=%h, required no load", rx_data);
         end else begin
            sb_e = exp_q.pop_front();
            if (rx_data !== sb_e) begin
               bad++;
               $display("FAIL sb_data: got %h, required %h", rx_data, sb_e);
            end
         end
         total++;
         if (prev_load === 1'b1) begin
            bad++;
            $display("FAIL sb_load_width: got load on consecutive cycles, required single-cycle pulse");
         end
      end
      prev_load = rx_load;
   end

   // Driver tasks
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (BD) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      start_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par);
`else
      if (par === 1'bx) rx = 1'b1;
`endif
      send_bit(stop);
   endtask

   // Reference model: frame-level effect of a received frame on the byte queue and flags
   task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
`ifdef UART_RX_PARITY_EN
      if ((^d) ^ par) m_perr = 1'b1;
`else
      if (par === 1'bx) m_ferr = m_ferr;
`endif
      if (stop) begin
         exp_q.push_back(d);
         if (m_rdy) m_ovr = 1'b1;
         m_rdy  = 1'b1;
         m_data = d;
      end else begin
         m_ferr = 1'b1;
      end
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      m_rdy  = 1'b0;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
      m_perr = 1'b0;
`endif
   endtask

   task automatic model_reset();
      m_data = 8'h00;
      m_rdy  = 1'b0;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
      m_perr = 1'b0;
`endif
      exp_q.delete();
   endtask

   // Tests
   task automatic test_reset();
      reset  = 1'b0;
      rx     = 1'b1;
      rx_ack = 1'b0;
      model_reset();
      idle(3);
      reset = 1'b1;
      idle(2);
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h, required 00", rx_data); end
      total++; if (rx_load !== 1'b0) begin bad++; $display("FAIL reset_load: got %b, required 0", rx_load); end
      total++; if (rx_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b, required 0", rx_rdy); end
      total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", rx_busy); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b, required 0", frame_err); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b, required 0", overrun); end
   endtask

   task automatic test_basic();
      int n0;
      n0 = load_cnt;
      model_frame(8'hA5, 1'b0, 1'b1);
      send_frame(8'hA5, 1'b0, 1'b1);
      idle(4);
      total++; if (load_cnt - n0 !== 1) begin bad++; $display("FAIL basic_loads: got %0d, required 1", load_cnt - n0); end
      total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h, required a5", rx_data); end
      total++; if (rx_rdy !== 1'b1) begin bad++; $display("FAIL basic_rdy: got %b, required 1", rx_rdy); end
      total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL basic_flags: got ferr=%b ovr=%b, required 0 0", frame_err, overrun); end
      total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b, required 0", rx_busy); end
      total++;
      if (last_load_cyc - start_cyc < LAT - 2 || last_load_cyc - start_cyc > LAT + 2) begin
         bad++; $display("FAIL basic_latency: got %0d clks, required %0d +/-2", last_load_cyc - start_cyc, LAT);
      end
   endtask

   task automatic test_glitch();
      int n0;
      do_ack();
      n0 = load_cnt;
      rx = 1'b0;
      idle(4);
      total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_rise: got %b, required 1", rx_busy); end
      rx = 1'b1;
      idle(20);
      total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b, required 0", rx_busy); end
      total++; if (load_cnt !== n0) begin bad++; $display("FAIL glitch_loads: got %0d, required %0d", load_cnt, n0); end
      total++;
      if (rx_rdy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
         bad++; $display("FAIL glitch_flags: got rdy=%b ferr=%b ovr=%b, required 0 0 0", rx_rdy, frame_err, overrun);
      end
   endtask

   task automatic test_frame_err();
      int n0;
      n0 = load_cnt;
      model_frame(8'h3C, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0);
      idle(40);
      total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set: got %b, required 1", frame_err); end
      total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_low: got %b, required 1", rx_busy); end
      total++; if (rx_data !== m_data) begin bad++; $display("FAIL ferr_data: got %h, required %h", rx_data, m_data); end
      total++; if (load_cnt !== n0) begin bad++; $display("FAIL ferr_loads: got %0d, required %0d", load_cnt, n0); end
      rx = 1'b1;
      idle(5);
      total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_release: got %b, required 0", rx_busy); end
      do_ack();
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_ack: got %b, required 0", frame_err); end
   endtask

   task automatic test_back_to_back();
      model_frame(8'h11, 1'b0, 1'b1);
      model_frame(8'h22, 1'b0, 1'b1);
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      idle(4);
      total++; if (rx_data !== 8'h22) begin bad++; $display("FAIL b2b_data: got %h, required 22", rx_data); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_ovr: got %b, required 1", overrun); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_pending: got %0d bytes missing, required 0", exp_q.size()); end
      do_ack();
      total++; if (rx_rdy !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL b2b_ack: got rdy=%b ovr=%b, required 0 0", rx_rdy, overrun); end
   endtask

   task automatic test_reset_abort();
      int n0;
      n0 = load_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      idle(BD / 2);
      reset = 1'b0;
      model_reset();
      idle(2);
      reset = 1'b1;
      idle(BD * 5);
      total++; if (load_cnt !== n0) begin bad++; $display("FAIL abort_loads: got %0d, required %0d", load_cnt, n0); end
      total++; if (rx_busy !== 1'b0 || rx_data !== 8'h00) begin bad++; $display("FAIL abort_state: got busy=%b data=%h, required 0 00", rx_busy, rx_data); end
      model_frame(8'h0F, 1'b0, 1'b1);
      send_frame(8'h0F, 1'b0, 1'b1);
      idle(4);
      total++; if (rx_data !== 8'h0F) begin bad++; $display("FAIL abort_next_data: got %h, required 0f", rx_data); end
      total++; if (rx_rdy !== 1'b1) begin bad++; $display("FAIL abort_next_rdy: got %b, required 1", rx_rdy); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      do_ack();
      model_frame(8'h07, 1'b0, 1'b1);
      send_frame(8'h07, 1'b0, 1'b1);
      idle(4);
      total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_bad: got %b, required 1", parity_err); end
      total++; if (rx_data !== 8'h07) begin bad++; $display("FAIL par_bad_data: got %h, required 07", rx_data); end
      do_ack();
      model_frame(8'h07, 1'b1, 1'b1);
      send_frame(8'h07, 1'b1, 1'b1);
      idle(4);
      total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_good: got %b, required 0", parity_err); end
   endtask
`endif

   task automatic test_random();
      logic [7:0] d;
      logic       par;
      logic       stop;
      for (int k = 0; k < 12; k++) begin
         d    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 4) != 0);
         par  = (^d) ^ ($urandom_range(0, 5) == 0);
         model_frame(d, par, stop);
         send_frame(d, par, stop);
         rx = 1'b1;
         idle(4 + $urandom_range(0, 12));
         total++; if (rx_data !== m_data) begin bad++; $display("FAIL rnd_data[%0d]: got %h, required %h", k, rx_data, m_data); end
         total++;
         if (rx_rdy !== m_rdy || overrun !== m_ovr || frame_err !== m_ferr) begin
            bad++;
            $display("FAIL rnd_flags[%0d]: got rdy=%b ovr=%b ferr=%b, required %b %b %b", k, rx_rdy, overrun, frame_err, m_rdy, m_ovr, m_ferr);
         end
`ifdef UART_RX_PARITY_EN
         total++; if (parity_err !== m_perr) begin bad++; $display("FAIL rnd_perr[%0d]: got %b, required %b", k, parity_err, m_perr); end
`endif
         total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rnd_busy[%0d]: got %b, required 0", k, rx_busy); end
         if ($urandom_range(0, 1) == 1) do_ack();
      end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_pending: got %0d bytes missing, required 0", exp_q.size()); end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      load_cnt  = 0;
      prev_load = 1'b0;
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_abort();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
